// File: rtl/fp8_mul_sequencer_if.sv
// Operand and result streams of the FP8 multiplier sequencer.
// The sequencer takes the slave side; the producer/consumer takes the master side.
interface fp8_mul_sequencer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;

    modport master (
        output in_data, in_valid, res_ready,
        input  in_ready, res_data, res_valid
    );

    modport slave (
        input  in_data, in_valid, res_ready,
        output in_ready, res_data, res_valid
    );
endinterface

// File: rtl/fp8_mul_sequencer.sv
// Registered, flow-controlled wrapper around the combinational FP8 multiplier.
// Optional macro FP8_ZERO_BYPASS_EN: a zero operand skips the settle wait.
module fp8_mul_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    fp8_mul_sequencer_if.slave          bus,
    output logic [7:0]                  op_a,
    output logic [7:0]                  op_b,
    input  logic [7:0]                  mul_result,
    output logic                        busy
);
    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        EVAL   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [7:0] op_a_q;
    logic [7:0] op_b_q;
    logic [7:0] res_data_q;
    logic       res_valid_q;
    logic [3:0] cnt_q;

`ifdef FP8_ZERO_BYPASS_EN
    // op_b_q already holds the just-accepted B on the first EVAL cycle.
    logic zero_operand;
    assign zero_operand = (op_a_q[6:0] == 7'd0) || (op_b_q[6:0] == 7'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD_A;
            op_a_q      <= 8'h00;
            op_b_q      <= 8'h00;
            res_data_q  <= 8'h00;
            res_valid_q <= 1'b0;
            cnt_q       <= 4'd0;
        end else if (flush) begin
            state_q     <= LOAD_A;
            res_valid_q <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (bus.in_valid) begin
                        op_a_q  <= bus.in_data;
                        state_q <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (bus.in_valid) begin
                        op_b_q  <= bus.in_data;
                        cnt_q   <= 4'd0;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    cnt_q <= cnt_q + 4'd1;
`ifdef FP8_ZERO_BYPASS_EN
                    if (zero_operand) begin
                        res_data_q  <= {op_a_q[7] ^ op_b_q[7], 7'b0};
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end else
`endif
                    if (cnt_q == LAST_CNT) begin
                        res_data_q  <= mul_result;
                        res_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= LOAD_A;
                    end
                end
                default: state_q <= LOAD_A;
            endcase
        end
    end

    // A flush cycle must never complete an operand handshake.
    assign bus.in_ready  = ((state_q == LOAD_A) || (state_q == LOAD_B)) && !flush;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign busy          = (state_q != LOAD_A);
endmodule

// File: tb/tb_fp8_mul_sequencer.sv
// Directed bench: three sequencer instances with settle times 1, 4 and 8.
module tb_fp8_mul_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FP8_ZERO_BYPASS_EN
    localparam int         ZB_LAT  = 1;
    localparam logic [7:0] ZB_DATA = 8'h80;
`else
    localparam int         ZB_LAT  = 8;
    localparam logic [7:0] ZB_DATA = 8'h5B;
`endif

    fp8_mul_sequencer_if if0 ();
    fp8_mul_sequencer_if if1 ();
    fp8_mul_sequencer_if if2 ();
    logic       flush0, flush1, flush2;
    logic [7:0] mul0, mul1, mul2;
    logic [7:0] op_a0, op_b0, op_a1, op_b1, op_a2, op_b2;
    logic       busy0, busy1, busy2;

    fp8_mul_sequencer #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush0), .bus(if0.slave),
        .op_a(op_a0), .op_b(op_b0), .mul_result(mul0), .busy(busy0));
    fp8_mul_sequencer #(.SETTLE_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush1), .bus(if1.slave),
        .op_a(op_a1), .op_b(op_b1), .mul_result(mul1), .busy(busy1));
    fp8_mul_sequencer #(.SETTLE_CYCLES(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(if2.slave),
        .op_a(op_a2), .op_b(op_b2), .mul_result(mul2), .busy(busy2));

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        flush0 = 0; flush1 = 0; flush2 = 0;
        mul0 = 8'h00; mul1 = 8'h00; mul2 = 8'h00;
        if0.in_data = 0; if0.in_valid = 0; if0.res_ready = 0;
        if1.in_data = 0; if1.in_valid = 0; if1.res_ready = 0;
        if2.in_data = 0; if2.in_valid = 0; if2.res_ready = 0;

        // Reset state
        #3;
        check_eq("rst in_ready", 32'(if0.in_ready), 1);
        check_eq("rst busy", 32'(busy0), 0);
        check_eq("rst res_valid", 32'(if0.res_valid), 0);
        check_eq("rst res_data", 32'(if0.res_data), 8'h00);
        check_eq("rst op_a", 32'(op_a0), 8'h00);
        tick();
        rst_n = 1'b1;

        // Basic flow
        if0.in_valid = 1; if0.in_data = 8'h48; mul0 = 8'h5A;
        tick();
        check_eq("basic op_a", 32'(op_a0), 8'h48);
        check_eq("basic busy A", 32'(busy0), 1);
        if0.in_data = 8'h40;
        tick();
        if0.in_valid = 0;
        check_eq("basic op_b", 32'(op_b0), 8'h40);
        check_eq("basic eval in_ready", 32'(if0.in_ready), 0);
        check_eq("basic eval res_valid", 32'(if0.res_valid), 0);
        tick();
        check_eq("basic res_valid", 32'(if0.res_valid), 1);
        check_eq("basic res_data", 32'(if0.res_data), 8'h5A);
        if0.res_ready = 1;
        tick();
        if0.res_ready = 0;
        check_eq("basic done res_valid", 32'(if0.res_valid), 0);
        check_eq("basic done busy", 32'(busy0), 0);
        check_eq("basic done in_ready", 32'(if0.in_ready), 1);
        check_eq("basic op_a kept", 32'(op_a0), 8'h48);

        // Backpressure
        if0.in_valid = 1; if0.in_data = 8'h11; mul0 = 8'h33;
        tick();
        if0.in_data = 8'h22;
        tick();
        if0.in_data = 8'h77;
        tick();
        for (int i = 0; i < 10; i++) begin
            check_eq("bp res_valid", 32'(if0.res_valid), 1);
            check_eq("bp res_data", 32'(if0.res_data), 8'h33);
            check_eq("bp in_ready", 32'(if0.in_ready), 0);
            check_eq("bp op_a", 32'(op_a0), 8'h11);
            mul0 = 8'(8'h40 + i);
            tick();
        end
        if0.res_ready = 1;
        tick();
        if0.res_ready = 0; if0.in_valid = 0;
        check_eq("bp release in_ready", 32'(if0.in_ready), 1);
        check_eq("bp release res_valid", 32'(if0.res_valid), 0);
        check_eq("bp op_a not 77", 32'(op_a0), 8'h11);

        // Input stall between A and B
        if0.in_valid = 1; if0.in_data = 8'h48; mul0 = 8'h5A;
        tick();
        if0.in_valid = 0; if0.in_data = 8'hEE;
        for (int i = 0; i < 5; i++) tick();
        check_eq("stall busy", 32'(busy0), 1);
        check_eq("stall in_ready", 32'(if0.in_ready), 1);
        check_eq("stall op_a", 32'(op_a0), 8'h48);
        check_eq("stall op_b kept", 32'(op_b0), 8'h22);
        if0.in_valid = 1; if0.in_data = 8'h40;
        tick();
        if0.in_valid = 0;
        tick();
        check_eq("stall res_valid", 32'(if0.res_valid), 1);
        check_eq("stall res_data", 32'(if0.res_data), 8'h5A);
        if0.res_ready = 1;
        tick();
        if0.res_ready = 0;

        // Flush during EVAL
        if0.in_valid = 1; if0.in_data = 8'h10;
        tick();
        if0.in_data = 8'h20;
        tick();
        if0.in_valid = 0;
        flush0 = 1;
        #1;
        check_eq("flush in_ready forced", 32'(if0.in_ready), 0);
        tick();
        flush0 = 0;
        #1;
        check_eq("flush res_valid", 32'(if0.res_valid), 0);
        check_eq("flush in_ready", 32'(if0.in_ready), 1);
        check_eq("flush busy", 32'(busy0), 0);
        check_eq("flush op_b kept", 32'(op_b0), 8'h20);
        check_eq("flush res_data kept", 32'(if0.res_data), 8'h5A);
        tick();
        check_eq("flush res_valid later", 32'(if0.res_valid), 0);
        // Beat offered during flush is dropped
        flush0 = 1; if0.in_valid = 1; if0.in_data = 8'h99;
        tick();
        flush0 = 0; if0.in_valid = 0;
        check_eq("flush beat op_a", 32'(op_a0), 8'h10);
        check_eq("flush beat busy", 32'(busy0), 0);

        // Settle timing, SETTLE_CYCLES = 4
        if1.in_valid = 1; if1.in_data = 8'h30; mul1 = 8'h11;
        tick();
        tick();
        if1.in_valid = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 2) mul1 = 8'h22;
            check_eq($sformatf("settle valid e%0d", i), 32'(if1.res_valid), (i == 4) ? 1 : 0);
        end
        check_eq("settle res_data", 32'(if1.res_data), 8'h22);
        if1.res_ready = 1;
        tick();
        if1.res_ready = 0;
        check_eq("settle done busy", 32'(busy1), 0);

        // Zero operand, SETTLE_CYCLES = 8
        if2.in_valid = 1; if2.in_data = 8'hC8; mul2 = 8'h5B;
        tick();
        if2.in_data = 8'h00;
        tick();
        if2.in_valid = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_eq($sformatf("zero valid e%0d", i), 32'(if2.res_valid), (i >= ZB_LAT) ? 1 : 0);
        end
        check_eq("zero res_data", 32'(if2.res_data), ZB_DATA);

        // Asynchronous reset while in HOLD
        if0.in_valid = 1; if0.in_data = 8'h48; mul0 = 8'h5A;
        tick();
        if0.in_data = 8'h40;
        tick();
        if0.in_valid = 0;
        tick();
        check_eq("pre-rst res_valid", 32'(if0.res_valid), 1);
        #2;
        rst_n = 0;
        #1;
        check_eq("async rst res_valid", 32'(if0.res_valid), 0);
        check_eq("async rst res_data", 32'(if0.res_data), 8'h00);
        check_eq("async rst op_a", 32'(op_a0), 8'h00);
        check_eq("async rst busy", 32'(busy0), 0);
        check_eq("async rst in_ready", 32'(if0.in_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
